// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key schedule and round datapath.
package aes_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_WORDS  = 4;
    localparam int unsigned NUM_ROUNDS = 10;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t key_t [0:NUM_WORDS-1];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_EXPAND = 2'd2
    } state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for round r; zero outside 1..10.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        rcon_of = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (4'(i) == r) begin
                rcon_of = RCON[i];
            end
        end
    endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box lookup, shared with the sub_bytes stage.
module sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign result = SBOX[data];

endmodule

// File: rtl/key_scheduler.sv
// Sequential AES-128 key expansion: one 32-bit schedule word per cycle,
// round key published atomically after all four words are computed.
module key_scheduler #(
    parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        key_load,
    input  logic [31:0] cipher_key [0:3],
    input  logic        next_key,
    output logic [31:0] round_key  [0:3],
    output logic [3:0]  round_num,
    output logic        key_valid,
    output logic        busy
);

    import aes_pkg::*;

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    key_t        work, work_nxt, rk_nxt, work_upd;
    logic [3:0]  rn_nxt;
    logic [3:0]  rnd;
    word_t       rot_w3;
    word_t       sub_w3;

    assign rot_w3 = {work[3][23:0], work[3][31:24]};
    assign rnd    = round_num + 4'd1;

    // SubWord on the rotated last working word.
    for (genvar b = 0; b < 4; b++) begin : g_subword
        sbox u_sbox (
            .data   (rot_w3[8*b +: 8]),
            .result (sub_w3[8*b +: 8])
        );
    end

    // Working words after the update selected by the word index.
    always_comb begin
        work_upd = work;
        unique case (idx)
            2'd0: work_upd[0] = work[0] ^ sub_w3 ^ {rcon_of(rnd), 24'h0};
            2'd1: work_upd[1] = work[1] ^ work[0];
            2'd2: work_upd[2] = work[2] ^ work[1];
            2'd3: work_upd[3] = work[3] ^ work[2];
            default: work_upd = work;
        endcase
    end

    // Next-state, word index and key register updates; load has priority.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        work_nxt  = work;
        rk_nxt    = round_key;
        rn_nxt    = round_num;

        if (key_load) begin
            state_nxt = ST_READY;
            idx_nxt   = 2'd0;
            work_nxt  = cipher_key;
            rk_nxt    = cipher_key;
            rn_nxt    = 4'd0;
        end else begin
            unique case (state)
                ST_READY: begin
                    if (next_key && (round_num < 4'(NUM_ROUNDS))) begin
                        state_nxt = ST_EXPAND;
                        idx_nxt   = 2'd0;
                    end
                end
                ST_EXPAND: begin
                    work_nxt = work_upd;
                    idx_nxt  = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_nxt = ST_READY;
                        rk_nxt    = work_upd;
                        rn_nxt    = round_num + 4'd1;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            work      <= '{default: '0};
            round_key <= '{default: '0};
            round_num <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            work      <= work_nxt;
            round_key <= rk_nxt;
            round_num <= rn_nxt;
            key_valid <= (state_nxt == ST_READY);
            busy      <= (state_nxt == ST_EXPAND);
        end
    end

endmodule

// File: tb/tb_key_scheduler.sv
// Directed bench for key_scheduler using FIPS-197 and all-zero key vectors.
module tb_key_scheduler;

    logic        clk;
    logic        n_rst;
    logic        key_load;
    logic [31:0] cipher_key [0:3];
    logic        next_key;
    logic [31:0] round_key  [0:3];
    logic [3:0]  round_num;
    logic        key_valid;
    logic        busy;

    int n_cmp;
    int n_bad;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;

    key_scheduler dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .key_load   (key_load),
        .cipher_key (cipher_key),
        .next_key   (next_key),
        .round_key  (round_key),
        .round_num  (round_num),
        .key_valid  (key_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rk_flat();
        return {round_key[0], round_key[1], round_key[2], round_key[3]};
    endfunction

    task automatic set_key(input logic [127:0] k);
        cipher_key[0] = k[127:96];
        cipher_key[1] = k[95:64];
        cipher_key[2] = k[63:32];
        cipher_key[3] = k[31:0];
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [3:0] rn, input logic kv, input logic bz);
        check({tag, ".round_num"}, 128'(round_num), 128'(rn));
        check({tag, ".key_valid"}, 128'(key_valid), 128'(kv));
        check({tag, ".busy"},      128'(busy),      128'(bz));
    endtask

    task automatic do_load(input logic [127:0] k);
        set_key(k);
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Accept one request and run the four compute edges.
    task automatic do_advance();
        next_key = 1'b1;
        tick();
        next_key = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        n_rst    = 1'b0;
        key_load = 1'b0;
        next_key = 1'b0;
        set_key(128'h0);

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            key_load = 1'($urandom);
            next_key = 1'($urandom);
            set_key({$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        check("rst.round_key", rk_flat(), 128'h0);
        check_status("rst", 4'd0, 1'b0, 1'b0);

        key_load = 1'b0;
        next_key = 1'b0;
        n_rst    = 1'b1;
        tick();
        next_key = 1'b1;
        tick();
        next_key = 1'b0;
        tick();
        check_status("idle_next", 4'd0, 1'b0, 1'b0);
        check("idle_next.round_key", rk_flat(), 128'h0);

        // FIPS-197 load and first round with latency checks.
        do_load(FIPS_KEY);
        check("load.round_key", rk_flat(), FIPS_KEY);
        check_status("load", 4'd0, 1'b1, 1'b0);

        next_key = 1'b1;
        tick();
        next_key = 1'b0;
        check_status("e0", 4'd0, 1'b0, 1'b1);
        check("e0.round_key", rk_flat(), FIPS_KEY);
        repeat (3) tick();
        check_status("e3", 4'd0, 1'b0, 1'b1);
        check("e3.round_key", rk_flat(), FIPS_KEY);
        tick();
        check("r1.round_key", rk_flat(), FIPS_R1);
        check_status("r1", 4'd1, 1'b1, 1'b0);

        // Remaining rounds, each request on the first READY cycle.
        for (int r = 2; r <= 10; r++) begin
            do_advance();
            check("sched.round_num", 128'(round_num), 128'(r));
            if (r == 2)  check("r2.round_key", rk_flat(), FIPS_R2);
            if (r == 10) check("r10.round_key", rk_flat(), FIPS_R10);
        end
        check_status("r10", 4'd10, 1'b1, 1'b0);

        next_key = 1'b1;
        tick();
        check_status("r11_req", 4'd10, 1'b1, 1'b0);
        next_key = 1'b0;
        tick();
        check("r11_req.round_key", rk_flat(), FIPS_R10);
        check_status("r11_after", 4'd10, 1'b1, 1'b0);

        // Abort an expansion at word index 2 with an all-zero key.
        do_load(FIPS_KEY);
        next_key = 1'b1;
        tick();
        next_key = 1'b0;
        repeat (2) tick();
        set_key(128'h0);
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("abort.round_key", rk_flat(), 128'h0);
        check_status("abort", 4'd0, 1'b1, 1'b0);
        do_advance();
        check("zero_r1.round_key", rk_flat(), ZERO_R1);
        check_status("zero_r1", 4'd1, 1'b1, 1'b0);

        // Load and request together: load only.
        set_key(FIPS_KEY);
        key_load = 1'b1;
        next_key = 1'b1;
        tick();
        key_load = 1'b0;
        next_key = 1'b0;
        check("simul.round_key", rk_flat(), FIPS_KEY);
        check_status("simul", 4'd0, 1'b1, 1'b0);
        tick();
        check_status("simul_after", 4'd0, 1'b1, 1'b0);

        // Request held through the whole expansion: one advance.
        next_key = 1'b1;
        repeat (4) tick();
        check_status("held_e3", 4'd0, 1'b0, 1'b1);
        tick();
        next_key = 1'b0;
        check("held_e4.round_key", rk_flat(), FIPS_R1);
        check_status("held_e4", 4'd1, 1'b1, 1'b0);
        tick();
        check_status("held_e5", 4'd1, 1'b1, 1'b0);

        // Asynchronous reset between edges in the middle of an expansion.
        next_key = 1'b1;
        tick();
        next_key = 1'b0;
        tick();
        check_status("pre_arst", 4'd1, 1'b0, 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst.round_key", rk_flat(), 128'h0);
        check_status("arst", 4'd0, 1'b0, 1'b0);
        tick();
        n_rst = 1'b1;
        tick();
        check_status("arst_idle", 4'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_scheduler.md
# key_scheduler

Sequential AES-128 key expansion engine feeding the `add_roundkey` stage. It loads the 128-bit cipher key and presents it as round key 0. On each request it computes the next round key, one 32-bit word per cycle, and publishes all four words at once when done. Round keys are produced in encryption order, 0 through 10, on the same `round_key[0:3]` word array that `add_roundkey` consumes.

## Interface
- `NUM_ROUNDS`, default 10: last round index. Fixed for AES-128; not meant to be overridden.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `key_load` in 1: single-cycle pulse; capture `cipher_key` as round 0.
- `cipher_key` in [31:0] x [0:3]: cipher key words w0..w3. Byte [31:24] of w0 is key byte 0.
- `next_key` in 1: request the next round key. Sampled only in READY.
- `round_key` out [31:0] x [0:3]: current round key, same word/byte order as `cipher_key`.
- `round_num` out 4: index of the key currently on `round_key`, 0..10.
- `key_valid` out 1: `round_key` is stable and matches `round_num`.
- `busy` out 1: expansion in progress.

## Operation
- States:
  - IDLE: no key loaded.
  - READY: key valid.
  - EXPAND: computing words 0..3, tracked by a 2-bit word index.
- State transitions:
  - Any state with `key_load`=1 → READY. Load `cipher_key` into both the committed and working registers; `round_num`=0.
  - READY with `next_key`=1 and `round_num` < NUM_ROUNDS → EXPAND, word index 0.
  - EXPAND, word index 3 → READY. Commit the working registers to `round_key`; `round_num`+1.
- Per-word computation, with w = working words and r = `round_num`+1:
  - Index 0: w0 ^= SubWord(RotWord(w3)) ^ {RCON[r],24'h0}.
  - Index i = 1..3: wi ^= w(i-1), using the w(i-1) already updated this expansion.
- RotWord: {b1,b2,b3,b0}. SubWord: AES S-box applied to each byte.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- `round_key` changes only at commit or load. It is never partially updated.
- Boundary conditions:
  - `next_key` in IDLE, EXPAND, or READY with `round_num`=10: ignored. No state change; no queueing.
  - `key_load` during EXPAND: aborts the expansion and loads the new key.
  - `key_load` and `next_key` asserted together: load wins.
  - `n_rst` asserted mid-expansion: immediate return to reset values.

## Timing
- Reset values: `round_key` all words 32'h0, `round_num`=0, `key_valid`=0, `busy`=0, state IDLE.
- Load: after the edge that samples `key_load`=1, `round_key`=`cipher_key`, `key_valid`=1, `busy`=0.
- Advance latency is 4 cycles:
  - Edge E0 samples `next_key`=1. After E0: `busy`=1, `key_valid`=0, `round_key` holds the old value.
  - Edges E1–E4 compute words 0–3.
  - After E4: new `round_key`, `round_num`+1, `key_valid`=1, `busy`=0.
- `next_key` at E4 itself is not accepted, because the state is still EXPAND. The earliest next accept is E5.
- `busy` and `key_valid` are registered state decodes. They are never asserted together.

## Structure
- `aes_pkg` holds:
  - `typedef logic [31:0] word_t`
  - `typedef word_t key_t [0:3]`
  - RCON constant array
  - NUM_ROUNDS
  - state enum
- Sub-module `sbox`: combinational 8-bit S-box lookup. Instantiated 4 times here for SubWord. The same module is reused by the `sub_bytes` stage.
- Top-level: state and index registers, committed and working key registers, XOR datapath.

## Test plan
- Reset: hold `n_rst`=0 with random inputs → all outputs 0, IDLE. Pulse `next_key` after reset → no response.
- FIPS-197 load and round 1:
  - Load key 2b7e1516 28aed2a6 abf71588 09cf4f3c → `round_key` equals the key, `round_num`=0.
  - Then `next_key` → exactly 4 cycles later: a0fafe17 88542cb1 23a33939 2a6c7605, `round_num`=1.
- Full schedule: 10 back-to-back requests, each issued on the first READY cycle.
  - Round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - An 11th `next_key` → no change, `busy` stays 0.
- Abort:
  - `key_load` with key 0 at EXPAND word index 2 → next cycle READY, `round_key`=0, `round_num`=0.
  - Round 1 of the zero key = 62636363 62636363 62636363 62636363.
- Simultaneous and ignored requests:
  - `key_load`+`next_key` in the same cycle → load only, no expansion.
  - `next_key` held high during EXPAND → only one advance per accept.
- Async reset mid-EXPAND: drop `n_rst` between clock edges → outputs clear immediately, without waiting for a clock edge.
